// File: rtl/sp_mem_pkg.sv
// sp_mem_pkg: shared widths and FSM state type for the single-port memory controller
package sp_mem_pkg;
  localparam int DATA_W = 32;
  localparam int BE_W = 4;
  typedef enum logic [2:0] {IDLE, RD, RD_WAIT, RMW_RD, RMW_WAIT, WR, RESP} state_e;
endpackage

// File: rtl/sp_be_merge.sv
// sp_be_merge: byte-wise merge of new write data over the old RAM word
module sp_be_merge
  import sp_mem_pkg::*;
(
  input  logic [DATA_W-1:0] old_data,
  input  logic [DATA_W-1:0] new_data,
  input  logic [BE_W-1:0]   be,
  output logic [DATA_W-1:0] merged
);
  for (genvar b = 0; b < BE_W; b++) begin : g_byte
    assign merged[8*b +: 8] = be[b] ? new_data[8*b +: 8] : old_data[8*b +: 8];
  end
endmodule

// File: rtl/sp_mem_ctrl.sv
// sp_mem_ctrl: request/response front end for a single-port RAM with read-modify-write for partial writes
module sp_mem_ctrl
  import sp_mem_pkg::*;
#(
  parameter int READ_LAT = 1,
  parameter int ADDR_W   = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              ram_ce,
  output logic              ram_oce,
  output logic              ram_wre,
  output logic [ADDR_W-1:0] ram_ad,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);
  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d, din_q, din_d, merged;
  logic [BE_W-1:0]   be_q, be_d;
  logic [ADDR_W-1:0] ad_q, ad_d;
  logic              valid_q, valid_d, ce_q, ce_d, wre_q, wre_d;
  logic              wait_done;
  logic              unused_addr_lsb;
  assign unused_addr_lsb = ^req_addr[1:0];
  assign wait_done  = cnt_q == 2'(READ_LAT - 1);
  assign req_ready  = state_q == IDLE;
  assign resp_valid = valid_q;
  assign resp_rdata = rdata_q;
  assign ram_ce     = ce_q;
  assign ram_oce    = 1'b1;
  assign ram_wre    = wre_q;
  assign ram_ad     = ad_q;
  assign ram_din    = din_q;
  sp_be_merge u_merge (
    .old_data(ram_dout),
    .new_data(wdata_q),
    .be      (be_q),
    .merged  (merged)
  );
  // next state and registered outputs; RAM strobes are single-cycle pulses by default
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    ad_d    = ad_q;
    rdata_d = rdata_q;
    din_d   = din_q;
    valid_d = valid_q;
    ce_d    = 1'b0;
    wre_d   = 1'b0;
    case (state_q)
      IDLE: if (req_valid) begin
        ad_d    = req_addr[ADDR_W+1:2];
        wdata_d = req_wdata;
        be_d    = req_be;
        cnt_d   = '0;
        if (!req_we) begin
          state_d = RD;
          ce_d    = 1'b1;
        end else if (req_be == '0) begin
          state_d = RESP;
          valid_d = 1'b1;
          rdata_d = '0;
        end else if (req_be == '1) begin
          state_d = WR;
          ce_d    = 1'b1;
          wre_d   = 1'b1;
          din_d   = req_wdata;
        end else begin
          state_d = RMW_RD;
          ce_d    = 1'b1;
        end
      end
      RD:     state_d = RD_WAIT;
      RMW_RD: state_d = RMW_WAIT;
      RD_WAIT: if (wait_done) begin
        state_d = RESP;
        valid_d = 1'b1;
        rdata_d = ram_dout;
      end else cnt_d = cnt_q + 2'd1;
      RMW_WAIT: if (wait_done) begin
        state_d = WR;
        ce_d    = 1'b1;
        wre_d   = 1'b1;
        din_d   = merged;
      end else cnt_d = cnt_q + 2'd1;
      WR: begin
        state_d = RESP;
        valid_d = 1'b1;
        rdata_d = '0;
      end
      RESP: if (resp_ready) begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and output registers; reset drops any queued RAM write
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      ad_q    <= '0;
      rdata_q <= '0;
      din_q   <= '0;
      valid_q <= 1'b0;
      ce_q    <= 1'b0;
      wre_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      ad_q    <= ad_d;
      rdata_q <= rdata_d;
      din_q   <= din_d;
      valid_q <= valid_d;
      ce_q    <= ce_d;
      wre_q   <= wre_d;
    end
  end
endmodule

// File: doc/sp_mem_ctrl.md
SP_MEM_CTRL -- requirements
Module: sp_mem_ctrl

Interface
REQ-001 The block SHALL have parameter READ_LAT, default 1, meaning RAM read latency in cycles (legal: 1 bypass, 2 pipelined).
REQ-002 The block SHALL have parameter ADDR_W, default 14, meaning RAM word-address width.
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, meaning reset, synchronous and active-high.
REQ-005 The block SHALL have port req_valid, input, 1, meaning a request is present.
REQ-006 The block SHALL have port req_ready, output, 1, meaning the controller accepts a request this cycle.
REQ-007 The block SHALL have port req_we, input, 1, meaning 1 = write, 0 = read.
REQ-008 The block SHALL have port req_addr, input, ADDR_W+2, meaning byte address; bits [1:0] ignored.
REQ-009 The block SHALL have port req_wdata, input, 32, meaning write data.
REQ-010 The block SHALL have port req_be, input, 4, meaning byte enables; bit i selects wdata[8i+7:8i].
REQ-011 The block SHALL have port resp_valid, output, 1, meaning a response is present.
REQ-012 The block SHALL have port resp_ready, input, 1, meaning the consumer takes the response.
REQ-013 The block SHALL have port resp_rdata, output, 32, meaning read data (0 for write acks).
REQ-014 The block SHALL have ports ram_ce, ram_oce, ram_wre, ram_ad[ADDR_W-1:0], ram_din[31:0] (outputs) and ram_dout[31:0] (input), wired one-to-one to the single-port RAM ports ce, oce, wre, ad, din and dout.

Function
REQ-015 All outputs except req_ready and ram_oce SHALL be registered; ram_oce SHALL be constant 1.
REQ-016 The FSM SHALL have states IDLE, RD, RD_WAIT, RMW_RD, RMW_WAIT, WR, RESP.
REQ-017 req_ready SHALL be 1 only in IDLE; acceptance = req_valid & req_ready at edge T.
REQ-018 On acceptance, word address = req_addr[ADDR_W+1:2]; wdata and be SHALL be latched.
REQ-019 Read: at T+1 ram_ce=1, ram_wre=0; ram_dout SHALL be captured in cycle T+1+READ_LAT; resp_valid=1 from T+2+READ_LAT.
REQ-020 Full write (be=4'hF): at T+1 ram_ce=1, ram_wre=1, ram_din=wdata; resp_valid=1 from T+2.
REQ-021 Partial write (be neither 0 nor 4'hF): read at T+1, capture at T+1+READ_LAT, write of the merged word at T+2+READ_LAT, resp_valid from T+3+READ_LAT.
REQ-022 Merged word: byte i = wdata byte i if be[i] else old RAM byte i.
REQ-023 Write with be=0 SHALL perform no RAM access; resp_valid=1 from T+1.
REQ-024 be SHALL be ignored for reads.
REQ-025 ram_ce and ram_wre SHALL be 0 in every cycle not named in REQ-019 to REQ-021.
REQ-026 resp_valid and resp_rdata SHALL stay stable until resp_valid & resp_ready; the controller SHALL return to IDLE on that edge, so req_ready=1 in the next cycle.
REQ-027 Address ADDR_W all-ones SHALL be accessed normally, with no wrap beyond it.

Reset
REQ-028 At any edge with reset=1: state=IDLE; resp_valid=0; resp_rdata=0; ram_ce=0; ram_wre=0; ram_ad=0; ram_din=0.
REQ-029 Reset mid-operation SHALL abort it; a pending write whose RAM write cycle has not yet been driven SHALL NOT occur; req_ready=1 in the cycle after reset deasserts.

Structure
REQ-030 Package sp_mem_pkg SHALL hold the state enum typedef, DATA_W=32 and BE_W=4.
REQ-031 Byte merging SHALL live in one combinational sub-module sp_be_merge (old, new, be -> merged).

Verification
REQ-032 Reset, full write addr 0x0010 data 0xDEADBEEF -> resp at T+2; then read 0x0010 -> resp_rdata 0xDEADBEEF at T+3 (READ_LAT=1).
REQ-033 Partial write be=4'b0101 data 0x11223344 over 0xDEADBEEF -> a later read returns 0xDE22BE44.
REQ-034 Read with resp_ready held 0 for 5 cycles -> resp_valid and resp_rdata stable, req_ready=0 throughout.
REQ-035 Write be=0 to 0x0020 -> ram_ce never 1, ack at T+1, and the word is unchanged.
REQ-036 Reset during RMW_WAIT -> no ram_wre pulse, outputs at reset values, and the target word is unchanged.
REQ-037 READ_LAT=2 with the top address 0xFFFC -> data correct and resp_valid at T+4.
